apb4_seq_master: RTL and testbench

//  Synthesizable APB4 sequencing master that replaces hand-written smoke stimulus.

---
 rtl/apb4_seq_master.sv | 124 ++++++++++++
 tb/tb_apb4_seq_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_seq_master.sv
// APB4 sequencing master: walks a command table against one slave, checks read
// data under a per-command mask, counts errors and aborts on a stalled slave.
module apb4_seq_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_CMD = 16,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned ERR_W   = 8,
   parameter logic [2:0]  PROT    = 3'b000,
   localparam int unsigned STRB_W = DATA_W / 8,
   localparam int unsigned IDX_W  = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [IDX_W-1:0]  cmd_idx_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   input  logic [DATA_W-1:0] cmd_mask_i,
   input  logic [STRB_W-1:0] cmd_strb_i,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [2:0]        pprot_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [DATA_W-1:0] pwdata_o,
   output logic [STRB_W-1:0] pstrb_o,
   input  logic              pready_i,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pslverr_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [ERR_W-1:0]  err_cnt_o,
   output logic              timeout_o
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               to_q, to_d;
   logic               xfer_err;

   // A transfer counts at most once, whether it is a slave error, a miscompare, or both
   assign xfer_err = pslverr_i |
                     (!cmd_write_i && (|((prdata_i ^ cmd_data_i) & cmd_mask_i)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         wait_q  <= '0;
         err_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      err_d   = err_q;
      to_d    = to_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_SETUP;
               idx_d   = '0;
               wait_d  = '0;
               err_d   = '0;
               to_d    = 1'b0;
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (pready_i) begin
               wait_d = '0;
               if (xfer_err && (err_q != {ERR_W{1'b1}}))
                  err_d = err_q + ERR_W'(1);
               if (idx_q == IDX_W'(NUM_CMD - 1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_SETUP;
               end
            end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
               wait_d  = '0;
               to_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign psel_o    = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign penable_o = (state_q == S_ACCESS);
   assign busy_o    = psel_o;
   assign done_o    = (state_q == S_DONE);
   assign cmd_idx_o = idx_q;
   assign pprot_o   = PROT;
   assign paddr_o   = psel_o ? cmd_addr_i : '0;
   assign pwrite_o  = psel_o & cmd_write_i;
   assign pwdata_o  = pwrite_o ? cmd_data_i : '0;
   assign pstrb_o   = pwrite_o ? cmd_strb_i : '0;
   assign err_cnt_o = err_q;
   assign timeout_o = to_q;
   assign pass_o    = done_o && (err_q == '0) && !to_q;

endmodule

// File: tb/tb_apb4_seq_master.sv
// Scoreboard bench: stimulus pushes expected transfers/results, a negedge monitor
// pops and compares on each completed APB transfer and each rising done_o.
module tb_apb4_seq_master;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } xfer_t;

   typedef struct {
      logic [7:0] err;
      logic       pass;
      logic       to;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   always #5 clk = ~clk;

   // main DUT, 4-entry table
   logic [1:0]  cmd_idx;
   logic        cmd_write;
   logic [31:0] cmd_addr, cmd_data, cmd_mask;
   logic [3:0]  cmd_strb;
   logic [31:0] paddr, pwdata, prdata;
   logic [2:0]  pprot;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;
   logic        busy, done, pass, timeout;
   logic [7:0]  err_cnt;

   logic        t_w[4];
   logic [31:0] t_a[4], t_d[4], t_m[4], t_rd[4];
   logic [3:0]  t_s[4];
   int          t_wt[4];
   logic        t_er[4];
   int          wcnt = 0;

   assign cmd_write = t_w[cmd_idx];
   assign cmd_addr  = t_a[cmd_idx];
   assign cmd_data  = t_d[cmd_idx];
   assign cmd_mask  = t_m[cmd_idx];
   assign cmd_strb  = t_s[cmd_idx];
   assign prdata    = t_rd[cmd_idx];
   assign pslverr   = penable & t_er[cmd_idx];
   assign pready    = penable && (wcnt >= t_wt[cmd_idx]);

   always @(posedge clk) wcnt <= (psel && penable && !pready) ? wcnt + 1 : 0;

   apb4_seq_master #(.ADDR_W(32), .DATA_W(32), .NUM_CMD(4), .TIMEOUT(64), .ERR_W(8)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_idx_o(cmd_idx),
      .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
      .cmd_mask_i(cmd_mask), .cmd_strb_i(cmd_strb), .paddr_o(paddr), .pprot_o(pprot),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .pwdata_o(pwdata),
      .pstrb_o(pstrb), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr),
      .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt), .timeout_o(timeout)
   );

   // saturation DUT: 300 reads, every one answered with pslverr
   logic        s_start = 1'b0;
   logic [8:0]  s_idx;
   logic [31:0] s_paddr, s_pwdata;
   logic [2:0]  s_pprot;
   logic        s_psel, s_penable, s_pwrite, s_busy, s_done, s_pass, s_to;
   logic [3:0]  s_pstrb;
   logic [7:0]  s_err;

   apb4_seq_master #(.ADDR_W(32), .DATA_W(32), .NUM_CMD(300), .TIMEOUT(64), .ERR_W(8)) u_sat (
      .clk_i(clk), .rst_i(rst), .start_i(s_start), .cmd_idx_o(s_idx),
      .cmd_write_i(1'b0), .cmd_addr_i(32'h100), .cmd_data_i(32'h0),
      .cmd_mask_i(32'h0), .cmd_strb_i(4'h0), .paddr_o(s_paddr), .pprot_o(s_pprot),
      .psel_o(s_psel), .penable_o(s_penable), .pwrite_o(s_pwrite), .pwdata_o(s_pwdata),
      .pstrb_o(s_pstrb), .pready_i(1'b1), .prdata_i(32'h0), .pslverr_i(1'b1),
      .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_cnt_o(s_err), .timeout_o(s_to)
   );

   int n_chk = 0;
   int n_pass = 0;
   xfer_t xq[$];
   res_t  rq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic set_cmd(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] m, input logic [3:0] s, input logic [31:0] rd,
                          input int wt, input logic er);
      t_w[i] = w; t_a[i] = a; t_d[i] = d; t_m[i] = m; t_s[i] = s;
      t_rd[i] = rd; t_wt[i] = wt; t_er[i] = er;
   endtask

   task automatic push_x(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s);
      xfer_t x;
      x.addr = a; x.wr = w; x.wdata = d; x.strb = s;
      xq.push_back(x);
   endtask

   task automatic push_r(input logic [7:0] e, input logic p, input logic t);
      res_t r;
      r.err = e; r.pass = p; r.to = t;
      rq.push_back(r);
   endtask

   task automatic kick();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("wait_done_expired", 64'd0, 64'd1);
   endtask

   // T1 table: W 0x0, R 0x0, W 0x4 (low half), R 0x4 (low half masked)
   task automatic load_t1();
      set_cmd(0, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0,        4'hF, 32'h0,        0, 1'b0);
      set_cmd(1, 1'b0, 32'h0, 32'hA5A5A5A5, 32'hFFFFFFFF, 4'h0, 32'hA5A5A5A5, 0, 1'b0);
      set_cmd(2, 1'b1, 32'h4, 32'h00001234, 32'h0,        4'h3, 32'h0,        0, 1'b0);
      set_cmd(3, 1'b0, 32'h4, 32'h00001234, 32'h0000FFFF, 4'h0, 32'hBEEF1234, 0, 1'b0);
   endtask

   task automatic push_t1();
      push_x(32'h0, 1'b1, 32'hA5A5A5A5, 4'hF);
      push_x(32'h0, 1'b0, 32'h0, 4'h0);
      push_x(32'h4, 1'b1, 32'h00001234, 4'h3);
      push_x(32'h4, 1'b0, 32'h0, 4'h0);
   endtask

   logic  done_prev = 1'b0;
   xfer_t mx;
   res_t  mr;
   always @(negedge clk) begin
      if (!rst && psel && penable && pready) begin
         if (xq.size() == 0) chk("xfer_unexpected", 64'd1, 64'd0);
         else begin
            mx = xq.pop_front();
            chk("xfer_paddr", paddr, mx.addr);
            chk("xfer_pwrite", pwrite, mx.wr);
            chk("xfer_pwdata", pwdata, mx.wdata);
            chk("xfer_pstrb", pstrb, mx.strb);
         end
      end
      if (!rst && done && !done_prev) begin
         if (rq.size() == 0) chk("result_unexpected", 64'd1, 64'd0);
         else begin
            mr = rq.pop_front();
            chk("res_err_cnt", err_cnt, mr.err);
            chk("res_pass", pass, mr.pass);
            chk("res_timeout", timeout, mr.to);
         end
      end
      done_prev <= done;
   end

   initial begin
      #500000;
      $display("FAIL global_watchdog: got running expected finished");
      $fatal(1, "bench watchdog");
   end

   initial begin
      int n;
      logic stable;
      logic [31:0] a0;
      load_t1();
      repeat (3) @(negedge clk);
      chk("rst_psel", psel, 0);
      chk("rst_outputs", {cmd_idx, paddr, pprot, penable, pwrite, pwdata, pstrb},  64'd0);
      chk("rst_status", {busy, done, pass, err_cnt, timeout}, 64'd0);
      rst = 1'b0;

      // T1 zero-wait: done exactly 8 cycles after the start edge
      push_t1(); push_r(8'd0, 1'b1, 1'b0);
      kick();
      wait_done(100, n);
      chk("t1_latency", n, 8);
      chk("t1_done_bus_idle", {psel, penable, paddr}, 64'd0);

      // T2 masked compares plus a write answered with pslverr
      set_cmd(0, 1'b0, 32'h8, 32'h12345678, 32'h0000FFFF, 4'h0, 32'hFFFF5678, 0, 1'b0);
      set_cmd(1, 1'b0, 32'h8, 32'h12345678, 32'h0000FFFF, 4'h0, 32'h12340000, 0, 1'b0);
      set_cmd(2, 1'b1, 32'hC, 32'hDEADBEEF, 32'h0,        4'h5, 32'h0,        0, 1'b1);
      set_cmd(3, 1'b0, 32'hC, 32'h0,        32'h0,        4'hF, 32'hCAFEF00D, 0, 1'b0);
      push_x(32'h8, 1'b0, 32'h0, 4'h0);
      push_x(32'h8, 1'b0, 32'h0, 4'h0);
      push_x(32'hC, 1'b1, 32'hDEADBEEF, 4'h5);
      push_x(32'hC, 1'b0, 32'h0, 4'h0);
      push_r(8'd2, 1'b0, 1'b0);
      kick();
      wait_done(100, n);
      chk("t2_latency", n, 8);

      // T3 five wait states on cmd 1; a start pulse mid-run must be ignored
      load_t1(); t_wt[1] = 5;
      push_t1(); push_r(8'd0, 1'b1, 1'b0);
      kick();
      n = 0;
      while (!(penable && cmd_idx == 2'd1) && n < 50) begin @(negedge clk); n++; end
      n = 0; stable = 1'b1; a0 = paddr;
      while (penable && cmd_idx == 2'd1 && n < 20) begin
         if (paddr !== a0) stable = 1'b0;
         n++;
         start = (n == 2);
         @(negedge clk);
      end
      start = 1'b0;
      chk("t3_penable_cycles", n, 6);
      chk("t3_paddr_stable", stable, 1);
      wait_done(100, n);

      // T4 stuck slave: 64 ACCESS cycles then abort
      load_t1(); t_wt[0] = 1000;
      push_r(8'd0, 1'b0, 1'b1);
      kick();
      @(negedge clk);
      n = 0;
      while (penable && n < 200) begin n++; @(negedge clk); end
      chk("t4_access_cycles", n, 64);
      chk("t4_psel_released", psel, 0);
      chk("t4_timeout", {done, timeout, pass}, 64'b110);

      // T6 reset during a wait state of cmd 2, then a full rerun
      load_t1(); t_wt[2] = 3;
      push_x(32'h0, 1'b1, 32'hA5A5A5A5, 4'hF);
      push_x(32'h0, 1'b0, 32'h0, 4'h0);
      kick();
      n = 0;
      while (!(penable && cmd_idx == 2'd2) && n < 50) begin @(negedge clk); n++; end
      chk("t6_reached_cmd2", {penable, pready}, 64'b10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_bus", {cmd_idx, paddr, psel, penable, pwrite, pwdata, pstrb}, 64'd0);
      chk("t6_rst_status", {busy, done, pass, err_cnt, timeout}, 64'd0);
      push_t1(); push_r(8'd0, 1'b1, 1'b0);
      kick();
      wait_done(100, n);
      chk("t6_rerun_latency", n, 11);

      // T5 saturation on the 300-command instance, then restart clears
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      n = 0;
      while (!s_done && n < 1000) begin @(negedge clk); n++; end
      chk("t5_latency", n, 600);
      chk("t5_err_sat", s_err, 8'd255);
      chk("t5_status", {s_done, s_pass, s_to}, 64'b100);
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      chk("t5_restart_clear", {s_busy, s_err}, {1'b1, 8'd0});

      repeat (2) @(negedge clk);
      chk("xfer_queue_empty", xq.size(), 0);
      chk("result_queue_empty", rq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
